// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and byte-RAM bus between a load/store unit and lsu_mem_ctrl.
// The master side is the requester plus RAM; the slave side is the controller.
interface lsu_mem_ctrl_if;
  logic        ena;
  logic        in_rollback;
  logic        in_mem_ena;
  logic        in_mem_iswrite;
  logic [2:0]  in_mem_size;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem_write_data;
  logic        out_mem_ready;
  logic [31:0] out_mem_read_data;
  logic [31:0] out_ram_addr;
  logic [7:0]  out_ram_data;
  logic        out_ram_wr;
  logic [7:0]  in_ram_data;

  modport master (
    output ena, in_rollback, in_mem_ena, in_mem_iswrite, in_mem_size,
           in_mem_addr, in_mem_write_data, in_ram_data,
    input  out_mem_ready, out_mem_read_data, out_ram_addr, out_ram_data, out_ram_wr
  );

  modport slave (
    input  ena, in_rollback, in_mem_ena, in_mem_iswrite, in_mem_size,
           in_mem_addr, in_mem_write_data, in_ram_data,
    output out_mem_ready, out_mem_read_data, out_ram_addr, out_ram_data, out_ram_wr
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Serialises 1/2/4-byte loads and stores onto a byte-wide RAM with one-cycle read latency.
// Loads can be flushed by a rollback; committed stores always run to completion.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << ADDR_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  cnt_nx;
  logic        wr_q, wr_d;
  logic        ready_q, ready_d;

  function automatic logic [2:0] eff_size(input logic [2:0] s);
    case (s)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] k);
    case (k)
      3'd0:    return w[7:0];
      3'd1:    return w[15:8];
      3'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (k)
      3'd0:    r[7:0]   = b;
      3'd1:    r[15:8]  = b;
      3'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wbyte_q <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wbyte_q <= wbyte_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
    end
  end

  // cnt_q is the index of the byte whose address is on the RAM bus this cycle;
  // read bytes arrive one cycle later, so loads finish one edge after stores.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wbyte_d = wbyte_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    ready_d = 1'b0;
    cnt_nx  = cnt_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (bus.ena && bus.in_mem_ena && (bus.in_mem_iswrite || !bus.in_rollback)) begin
          base_d  = bus.in_mem_addr;
          wdata_d = bus.in_mem_write_data;
          size_d  = eff_size(bus.in_mem_size);
          cnt_d   = 3'd0;
          rbuf_d  = '0;
          addr_d  = bus.in_mem_addr;
          if (bus.in_mem_iswrite) begin
            state_d = WRITE;
            wbyte_d = byte_of(bus.in_mem_write_data, 3'd0);
            wr_d    = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_nx;
        if (cnt_nx == size_q) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          addr_d  = base_q + {29'd0, cnt_nx};
          wbyte_d = byte_of(wdata_q, cnt_nx);
          wr_d    = 1'b1;
        end
      end
      READ: begin
        if (bus.in_rollback) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_nx;
          if (cnt_q != 3'd0) begin
            rbuf_d = put_byte(rbuf_q, cnt_q - 3'd1, bus.in_ram_data);
          end
          if (cnt_q == size_q) begin
            state_d = IDLE;
            ready_d = 1'b1;
            rdata_d = rbuf_d;
          end else if (cnt_nx != size_q) begin
            addr_d = base_q + {29'd0, cnt_nx};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_mem_ready     = ready_q;
  assign bus.out_mem_read_data = rdata_q;
  assign bus.out_ram_addr      = addr_q & ADDR_MASK;
  assign bus.out_ram_data      = wbyte_q;
  assign bus.out_ram_wr        = wr_q;

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising-edge; all state on this clock.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: ena  in  1  global enable; low blocks acceptance of new requests, in-flight transfer continues.
REQ-004 SHALL have ports: in_rollback  in  1  misbranch flush.
REQ-005 SHALL have ports: in_mem_ena  in  1  request strobe, one-cycle pulse.
REQ-006 SHALL have ports: in_mem_iswrite  in  1  1=store, 0=load.
REQ-007 SHALL have ports: in_mem_size  in  3  byte count, 1/2/4; any other value treated as 4.
REQ-008 SHALL have ports: in_mem_addr  in  32  byte base address.
REQ-009 SHALL have ports: in_mem_write_data  in  32  store data, little-endian, low bytes used.
REQ-010 SHALL have ports: out_mem_ready  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: out_mem_read_data  out  32  load result, zero-extended (sign extension is the requester's job).
REQ-012 SHALL have ports: out_ram_addr  out  32  byte-RAM address.
REQ-013 SHALL have ports: out_ram_data  out  8  byte-RAM write data.
REQ-014 SHALL have ports: out_ram_wr  out  1  byte-RAM write strobe.
REQ-015 SHALL have ports: in_ram_data  in  8  byte-RAM read data, valid one cycle after address presented.
REQ-016 SHALL have parameter: ADDR_W, default 32, out_ram_addr width (upper bits zero when narrower than 32).

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ; E0 = edge accepting request, Ek = k-th edge after E0, S = effective size.
REQ-018 SHALL accept a request at an edge only when state=IDLE, ena=1, in_mem_ena=1; in_mem_ena while busy SHALL be ignored.
REQ-019 SHALL latch addr, data, size, iswrite at E0; requester inputs need not be held afterwards.
REQ-020 WRITE: during cycle after E(k), k=0..S-1, SHALL drive out_ram_addr=base+k, out_ram_data=byte k, out_ram_wr=1.
REQ-021 WRITE: at E(S) SHALL return to IDLE; out_mem_ready=1 for exactly the cycle after E(S).
REQ-022 READ: during cycle after E(k), k=0..S-1, SHALL drive out_ram_addr=base+k with out_ram_wr=0.
REQ-023 READ: SHALL capture in_ram_data as byte k at E(k+2); bytes >= S SHALL read as zero.
REQ-024 READ: at E(S+1) SHALL return to IDLE, update out_mem_read_data, and pulse out_mem_ready for the cycle after E(S+1).
REQ-025 out_mem_read_data SHALL hold its last value until the next load completion; unchanged by store completions.
REQ-026 out_ram_wr SHALL be 0 in every cycle not covered by REQ-020; out_ram_addr/data hold last value when idle.
REQ-027 Address arithmetic SHALL wrap modulo 2^32 (base 0xFFFFFFFF, k=1 -> 0x00000000).
REQ-028 in_rollback=1 during READ SHALL abort: IDLE at that edge, no ready pulse, read data unchanged.
REQ-029 in_rollback=1 during WRITE SHALL be ignored; the committed store completes normally.
REQ-030 in_rollback=1 at the same edge as an acceptable request: load SHALL be dropped, store SHALL be accepted.
REQ-031 A new request SHALL be acceptable at the edge where the previous transfer returns to IDLE+1 onward (no acceptance at the return edge itself).

Reset
REQ-032 rst=1 SHALL immediately force IDLE, out_mem_ready=0, out_mem_read_data=0, out_ram_addr=0, out_ram_data=0, out_ram_wr=0.
REQ-033 rst asserted mid-transfer SHALL abandon it with no ready pulse; a partial store is not undone.

Verification
REQ-034 SB store addr=0x100 data=0xAABBCCDD -> one write 0xDD at 0x100 in cycle after E0; ready cycle after E1.
REQ-035 SW store addr=0x200 data=0x11223344 -> writes 0x44,0x33,0x22,0x11 at 0x200..0x203; ready cycle after E4.
REQ-036 LH load addr=0x300, RAM 0x300=0x80,0x301=0xFF -> out_mem_read_data=0x0000FF80, ready cycle after E3.
REQ-037 LW load started, in_rollback at E2 -> no ready pulse, out_ram_wr stays 0, next LB accepted and completes.
REQ-038 in_mem_ena pulsed during a busy SW, and rst asserted mid-LW -> second request ignored; reset clears all outputs to 0 asynchronously.
